mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
- Parametrised MEM pipeline stage: registers the EX→MEM payload under the shared stall vector and holds it while a data-SRAM load is in flight.
- Load read latency is configurable. The stage extracts and sign/zero-extends byte, halfword and word loads.
- Drives the WB payload and the ID forwarding path, plus a load-pending flag and a stall request for the stall controller.

Parameters:
- RD_LAT, 1, data-SRAM read latency in cycles after the load enters MEM (legal 0..7; 0 = rdata valid in the same cycle).
- PC_W, 32, PC width.
- RA_W, 5, register-file address width.
- STALL_W, 6, stall bus width; the stage uses bits 3 and 4.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall  in  STALL_W  stall vector: bit = 1 means Stop
- ex_valid  in  1  EX slot holds a real instruction
- ex_pc  in  PC_W  instruction PC
- ex_load  in  1  instruction is a load
- ex_ld_type  in  3  load type: 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW (others treated as LW)
- ex_addr_lo  in  2  byte offset of the load address
- ex_rf_we  in  1  register write enable
- ex_rf_waddr  in  RA_W  destination register
- ex_result  in  32  ALU result / store data bypass
- data_sram_rdata  in  32  SRAM read word
- wb_pc  out  PC_W  PC to WB
- wb_rf_we  out  1  write enable to WB
- wb_rf_waddr  out  RA_W  destination to WB
- wb_rf_wdata  out  32  write data to WB
- fwd_we  out  1  forwarding write enable to ID
- fwd_waddr  out  RA_W  forwarding destination
- fwd_wdata  out  32  forwarding data
- fwd_ld_pending  out  1  load in MEM whose data is not yet valid
- stallreq_mem  out  1  request freeze of stages 0..3

Behaviour:
- Pipeline register update, evaluated every cycle:
  - Capture enable cap = (stall[3]==0) && !busy.
  - cap=1 → register loads the EX fields, valid=ex_valid.
  - stall[3]==1 && stall[4]==0 && !busy → register cleared (bubble).
  - Otherwise → register holds.
- busy = valid && load && (wait_cnt != 0).
- Wait counter:
  - On capture of a valid load, wait_cnt ← RD_LAT; otherwise wait_cnt ← 0.
  - While busy, wait_cnt decrements by 1 per cycle, saturating at 0.
  - Data is valid in MEM cycle RD_LAT, counting the capture cycle as cycle 0.
- State view:
  - IDLE: valid=0.
  - ACTIVE: non-load, or load with wait_cnt==0.
  - WAIT: busy.
  - Transitions: IDLE/ACTIVE → WAIT on capture of a load with RD_LAT>0. WAIT → ACTIVE when wait_cnt reaches 0.
- Hold buffer:
  - In the first ACTIVE cycle of a load, if stall[3]==1, rdata is latched into hold_data and held ← 1.
  - While held=1, extraction uses hold_data instead of data_sram_rdata.
  - held clears on the next capture or bubble.
- Load extraction:
  - Byte lane = ex_addr_lo.
  - Halfword = addr_lo[1] (addr_lo[0] ignored).
  - LW ignores addr_lo; no misalignment exception.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Write data: rf_wdata = load ? extracted : ex_result.
- WB and forwarding outputs:
  - wb_rf_we = fwd_we = valid && rf_we && !busy.
  - WB/forwarding address and data are combinational from the register.
  - Data outputs are don't-care when the write enable is 0.
- Load-pending / stall request: fwd_ld_pending = stallreq_mem = busy.
- Reset: register, wait_cnt, hold_data and held are all cleared. Every output resets to 0; this includes reset asserted mid-WAIT.
- Boundary cases:
  - RD_LAT=0: busy is never asserted; behaviour is pure register + extraction.
  - stall[3]==1 while busy: no effect; counting continues.
  - Back-to-back loads: the second is captured in the cycle the first becomes ACTIVE, if stall[3]==0.

Decomposition:
- Shared defines/package: load-type codes (LB..LW), Stop/NoStop, STALL_W, bus widths.
- One sub-module, load_extract: combinational byte/halfword select plus extension from (word, addr_lo, ld_type).

Test Plan:
- Non-load (RD_LAT=1): ex_result=0x1234_5678, rf_waddr=5, we=1 → next cycle wb_rf_we=1, wdata=0x12345678, stallreq_mem=0.
- LB (RD_LAT=1): addr_lo=2, rdata=0x0080_0000 in cycle 1 → cycle 0: stallreq=1, fwd_ld_pending=1, wb_rf_we=0; cycle 1: wdata=0xFFFF_FF80.
- LHU (RD_LAT=3): addr_lo=2, rdata=0x8001_xxxx → stallreq high for 3 cycles; cycle 3: wdata=0x0000_8001.
- Hold buffer: LW completes (rdata=0xDEAD_BEEF) with stall[3]=1; rdata changes to 0 next cycle → wdata stays 0xDEADBEEF until capture.
- Bubble: stall[3]=1, stall[4]=0, not busy → next cycle all wb_*/fwd_* = 0.
- Reset in WAIT (RD_LAT=4): rst at cycle 2 → next cycle stallreq=0, wb_rf_we=0, wait_cnt=0.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// mem_stage_lsu_pkg: load-type codes, stall polarity and widths shared by the MEM stage.
package mem_stage_lsu_pkg;
  typedef enum logic [2:0] {
    LD_LB  = 3'd0,
    LD_LBU = 3'd1,
    LD_LH  = 3'd2,
    LD_LHU = 3'd3,
    LD_LW  = 3'd4
  } ld_type_e;
  localparam logic STOP        = 1'b1;
  localparam int   STALL_W_DEF = 6;
  localparam int   STALL_MEM   = 3;
  localparam int   STALL_WB    = 4;
  localparam int   DATA_W      = 32;
  localparam int   CNT_W       = 3;
endpackage

// File: rtl/mem_stage_lsu_load_extract.sv
// load_extract: byte/halfword lane select with sign or zero extension.
module load_extract
  import mem_stage_lsu_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr_lo,
  input  logic [2:0]        ld_type,
  output logic [DATA_W-1:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  always_comb begin
    b    = word[{addr_lo, 3'b000} +: 8];
    h    = addr_lo[1] ? word[31:16] : word[15:0];
    data = ld_type == LD_LB  ? {{24{b[7]}}, b} :
           ld_type == LD_LBU ? {24'b0, b} :
           ld_type == LD_LH  ? {{16{h[15]}}, h} :
           ld_type == LD_LHU ? {16'b0, h} : word;
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: MEM pipeline register that waits out the data-SRAM read
// latency, buffers completed load data across stalls and extracts the result.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int PC_W    = 32,
  parameter int RA_W    = 5,
  parameter int STALL_W = STALL_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               ex_valid,
  input  logic [PC_W-1:0]    ex_pc,
  input  logic               ex_load,
  input  logic [2:0]         ex_ld_type,
  input  logic [1:0]         ex_addr_lo,
  input  logic               ex_rf_we,
  input  logic [RA_W-1:0]    ex_rf_waddr,
  input  logic [DATA_W-1:0]  ex_result,
  input  logic [DATA_W-1:0]  data_sram_rdata,
  output logic [PC_W-1:0]    wb_pc,
  output logic               wb_rf_we,
  output logic [RA_W-1:0]    wb_rf_waddr,
  output logic [DATA_W-1:0]  wb_rf_wdata,
  output logic               fwd_we,
  output logic [RA_W-1:0]    fwd_waddr,
  output logic [DATA_W-1:0]  fwd_wdata,
  output logic               fwd_ld_pending,
  output logic               stallreq_mem
);
  logic              valid, load, rf_we, held, busy, cap, bub, unused;
  logic [2:0]        ld_type;
  logic [1:0]        addr_lo;
  logic [RA_W-1:0]   rf_waddr;
  logic [DATA_W-1:0] result, hold_data, ext, wdata;
  logic [PC_W-1:0]   pc;
  logic [CNT_W-1:0]  wait_cnt;
  assign busy   = valid && load && wait_cnt != '0;
  assign cap    = stall[STALL_MEM] != STOP && !busy;
  assign bub    = stall[STALL_MEM] == STOP && stall[STALL_WB] != STOP && !busy;
  assign unused = &{1'b0, stall};
  always_ff @(posedge clk) begin
    if (rst) begin
      valid     <= 1'b0;
      pc        <= '0;
      load      <= 1'b0;
      ld_type   <= '0;
      addr_lo   <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      result    <= '0;
      wait_cnt  <= '0;
      hold_data <= '0;
      held      <= 1'b0;
    end else if (cap) begin
      valid     <= ex_valid;
      pc        <= ex_pc;
      load      <= ex_load;
      ld_type   <= ex_ld_type;
      addr_lo   <= ex_addr_lo;
      rf_we     <= ex_rf_we;
      rf_waddr  <= ex_rf_waddr;
      result    <= ex_result;
      wait_cnt  <= ex_valid && ex_load ? CNT_W'(RD_LAT) : '0;
      held      <= 1'b0;
    end else if (bub) begin
      valid     <= 1'b0;
      pc        <= '0;
      load      <= 1'b0;
      ld_type   <= '0;
      addr_lo   <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      result    <= '0;
      wait_cnt  <= '0;
      held      <= 1'b0;
    end else begin
      wait_cnt <= busy ? wait_cnt - 1'b1 : wait_cnt;
      // first ACTIVE cycle of a stalled load: keep the word the SRAM returned
      if (valid && load && !busy && !held) begin
        hold_data <= data_sram_rdata;
        held      <= 1'b1;
      end
    end
  end
  load_extract u_extract (
    .word    (held ? hold_data : data_sram_rdata),
    .addr_lo (addr_lo),
    .ld_type (ld_type),
    .data    (ext)
  );
  assign wdata          = load ? ext : result;
  assign wb_pc          = pc;
  assign wb_rf_we       = valid && rf_we && !busy;
  assign wb_rf_waddr    = rf_waddr;
  assign wb_rf_wdata    = wdata;
  assign fwd_we         = wb_rf_we;
  assign fwd_waddr      = rf_waddr;
  assign fwd_wdata      = wdata;
  assign fwd_ld_pending = busy;
  assign stallreq_mem   = busy;
endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb_mem_stage_lsu: four MEM stages (read latency 0, 1, 3, 4) on shared stimulus,
// checked against a cycle-age reference model, directed tables and random traffic.
module tb_mem_stage_lsu;
  localparam int N = 4;
  function automatic int lat(int g);
    return g == 2 ? 3 : g == 3 ? 4 : g;
  endfunction
  typedef struct packed {
    logic        rst;
    logic [5:0]  stall;
    logic        v;
    logic        ld;
    logic [2:0]  ty;
    logic [1:0]  lo;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] res;
    logic [31:0] rd;
  } in_t;
  typedef struct {
    in_t         i;
    logic        we;
    logic [31:0] wd;
    logic        pend;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        ex_valid, ex_load, ex_rf_we;
  logic [2:0]  ex_ld_type;
  logic [1:0]  ex_addr_lo;
  logic [4:0]  ex_rf_waddr;
  logic [31:0] ex_pc, ex_result, rdata;
  logic [31:0] o_pc[N], o_wd[N], o_fwd[N];
  logic [4:0]  o_wa[N], o_fwa[N];
  logic        o_we[N], o_fwe[N], o_pend[N], o_sr[N];
  logic        mv[N], ml[N], mwe[N], mheld[N];
  logic [2:0]  mty[N];
  logic [1:0]  mlo[N];
  logic [4:0]  mwa[N];
  logic [31:0] mres[N], mpc[N], mhold[N];
  int          mage[N];
  int          n_chk = 0, n_fail = 0;
  logic [31:0] pc_ctr = 32'h100;
  vec_t        tab[11];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_stage_lsu #(.RD_LAT(lat(g))) u_dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .ex_valid        (ex_valid),
      .ex_pc           (ex_pc),
      .ex_load         (ex_load),
      .ex_ld_type      (ex_ld_type),
      .ex_addr_lo      (ex_addr_lo),
      .ex_rf_we        (ex_rf_we),
      .ex_rf_waddr     (ex_rf_waddr),
      .ex_result       (ex_result),
      .data_sram_rdata (rdata),
      .wb_pc           (o_pc[g]),
      .wb_rf_we        (o_we[g]),
      .wb_rf_waddr     (o_wa[g]),
      .wb_rf_wdata     (o_wd[g]),
      .fwd_we          (o_fwe[g]),
      .fwd_waddr       (o_fwa[g]),
      .fwd_wdata       (o_fwd[g]),
      .fwd_ld_pending  (o_pend[g]),
      .stallreq_mem    (o_sr[g])
    );
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic logic [31:0] mext(logic [31:0] w, logic [1:0] lo, logic [2:0] t);
    int b, h;
    b = int'((w >> (8 * int'(lo))) & 32'hff);
    h = int'((w >> (lo[1] ? 16 : 0)) & 32'hffff);
    case (t)
      3'd0:    return 32'(b >= 128 ? b - 256 : b);
      3'd1:    return 32'(b);
      3'd2:    return 32'(h >= 32768 ? h - 65536 : h);
      3'd3:    return 32'(h);
      default: return w;
    endcase
  endfunction
  function automatic logic mbusy(int i);
    return mv[i] && ml[i] && mage[i] < lat(i);
  endfunction
  task automatic mclr(int i, logic full);
    mv[i] = 0; ml[i] = 0; mwe[i] = 0; mty[i] = 0; mlo[i] = 0;
    mwa[i] = 0; mres[i] = 0; mpc[i] = 0; mage[i] = 0; mheld[i] = 0;
    if (full) mhold[i] = 0;
  endtask
  task automatic check_model();
    for (int i = 0; i < N; i++) begin
      logic b, we;
      logic [31:0] wd;
      b  = mbusy(i);
      we = mv[i] && mwe[i] && !b;
      wd = ml[i] ? mext(mheld[i] ? mhold[i] : rdata, mlo[i], mty[i]) : mres[i];
      chk($sformatf("pend%0d", i), 32'(o_pend[i]), 32'(b));
      chk($sformatf("stallreq%0d", i), 32'(o_sr[i]), 32'(b));
      chk($sformatf("wb_we%0d", i), 32'(o_we[i]), 32'(we));
      chk($sformatf("fwd_we%0d", i), 32'(o_fwe[i]), 32'(we));
      if (we) begin
        chk($sformatf("wb_wdata%0d", i), o_wd[i], wd);
        chk($sformatf("fwd_wdata%0d", i), o_fwd[i], wd);
        chk($sformatf("wb_waddr%0d", i), 32'(o_wa[i]), 32'(mwa[i]));
        chk($sformatf("fwd_waddr%0d", i), 32'(o_fwa[i]), 32'(mwa[i]));
        chk($sformatf("wb_pc%0d", i), o_pc[i], mpc[i]);
      end
    end
  endtask
  task automatic step_model();
    for (int i = 0; i < N; i++) begin
      logic b;
      b = mbusy(i);
      if (rst) mclr(i, 1'b1);
      else if (!stall[3] && !b) begin
        mv[i] = ex_valid; ml[i] = ex_load; mwe[i] = ex_rf_we; mty[i] = ex_ld_type;
        mlo[i] = ex_addr_lo; mwa[i] = ex_rf_waddr; mres[i] = ex_result; mpc[i] = ex_pc;
        mage[i] = 0; mheld[i] = 0;
      end else if (!stall[4] && !b) mclr(i, 1'b0);
      else if (b) mage[i]++;
      else if (mv[i] && ml[i] && !mheld[i]) begin
        mheld[i] = 1; mhold[i] = rdata;
      end
    end
  endtask
  task automatic cyc(in_t x);
    @(negedge clk);
    rst = x.rst; stall = x.stall; ex_valid = x.v; ex_load = x.ld; ex_ld_type = x.ty;
    ex_addr_lo = x.lo; ex_rf_we = x.we; ex_rf_waddr = x.wa; ex_result = x.res;
    rdata = x.rd; ex_pc = pc_ctr;
    pc_ctr += 4;
    #1;
    check_model();
    step_model();
  endtask
  function automatic in_t mk(logic [5:0] s, logic v, logic ld, logic [2:0] ty, logic [1:0] lo,
                             logic we, logic [4:0] wa, logic [31:0] res, logic [31:0] rd);
    return '{rst: 1'b0, stall: s, v: v, ld: ld, ty: ty, lo: lo, we: we, wa: wa, res: res, rd: rd};
  endfunction
  initial begin
    rst = 1; stall = 0; ex_valid = 0; ex_load = 0; ex_ld_type = 0; ex_addr_lo = 0;
    ex_rf_we = 0; ex_rf_waddr = 0; ex_result = 0; rdata = 0; ex_pc = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < N; i++) mclr(i, 1'b1);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_we%0d", i), 32'(o_we[i]), 32'd0);
      chk($sformatf("rst_pend%0d", i), 32'(o_pend[i]), 32'd0);
      chk($sformatf("rst_wdata%0d", i), o_wd[i], 32'd0);
      chk($sformatf("rst_pc%0d", i), o_pc[i], 32'd0);
    end
    tab[0]  = '{mk(6'h00, 1, 0, 0, 0, 1, 5, 32'h12345678, 0), 0, 0, 0};
    tab[1]  = '{mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'h12345678, 0};
    tab[2]  = '{mk(6'h00, 1, 1, 0, 2, 1, 7, 32'h11111111, 0), 0, 0, 0};
    tab[3]  = '{mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1};
    tab[4]  = '{mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 32'h00800000), 1, 32'hFFFFFF80, 0};
    tab[5]  = '{mk(6'h00, 1, 1, 4, 3, 1, 9, 0, 0), 0, 0, 0};
    tab[6]  = '{mk(6'h18, 0, 0, 0, 0, 0, 0, 0, 32'h12), 0, 0, 1};
    tab[7]  = '{mk(6'h18, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF), 1, 32'hDEADBEEF, 0};
    tab[8]  = '{mk(6'h18, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'hDEADBEEF, 0};
    tab[9]  = '{mk(6'h08, 0, 0, 0, 0, 0, 0, 0, 0), 1, 32'hDEADBEEF, 0};
    tab[10] = '{mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 32'h5a), 0, 0, 0};
    for (int k = 0; k < 11; k++) begin
      cyc(tab[k].i);
      chk($sformatf("tab%0d_we", k), 32'(o_we[1]), 32'(tab[k].we));
      chk($sformatf("tab%0d_pend", k), 32'(o_sr[1]), 32'(tab[k].pend));
      if (tab[k].we) chk($sformatf("tab%0d_wdata", k), o_wd[1], tab[k].wd);
    end
    chk("bubble_wdata", o_wd[1], 32'd0);
    chk("bubble_waddr", 32'(o_fwa[1]), 32'd0);
    chk("bubble_pc", o_pc[1], 32'd0);
    cyc(mk(6'h00, 1, 1, 3, 2, 1, 3, 0, 0));
    for (int k = 0; k < 3; k++) begin
      cyc(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 32'h80011234));
      chk($sformatf("lhu_pend_c%0d", k), 32'(o_sr[2]), 32'd1);
      chk($sformatf("lhu_we_c%0d", k), 32'(o_we[2]), 32'd0);
    end
    cyc(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 32'h80011234));
    chk("lhu_pend_done", 32'(o_sr[2]), 32'd0);
    chk("lhu_we_done", 32'(o_we[2]), 32'd1);
    chk("lhu_wdata", o_wd[2], 32'h00008001);
    cyc(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(6'h00, 1, 1, 4, 0, 1, 12, 0, 0));
    cyc(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    cyc(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    begin
      in_t r;
      r = mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 0);
      r.rst = 1'b1;
      cyc(r);
      chk("wait_pend_before_rst", 32'(o_sr[3]), 32'd1);
    end
    cyc(mk(6'h00, 0, 0, 0, 0, 0, 0, 0, 32'hFFFFFFFF));
    chk("rst_wait_pend", 32'(o_sr[3]), 32'd0);
    chk("rst_wait_we", 32'(o_we[3]), 32'd0);
    chk("rst_wait_wdata", o_wd[3], 32'd0);
    chk("rst_wait_pc", o_pc[3], 32'd0);
    cyc(mk(6'h18, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_wait_cnt_zero", 32'(o_sr[3]), 32'd0);
    for (int k = 0; k < 3000; k++) begin
      in_t x;
      x.rst   = $urandom_range(0, 99) == 0;
      x.stall = 6'($urandom);
      x.stall[3] = $urandom_range(0, 9) < 3;
      x.stall[4] = 1'($urandom_range(0, 1));
      x.v     = $urandom_range(0, 3) != 0;
      x.ld    = 1'($urandom_range(0, 1));
      x.ty    = 3'($urandom_range(0, 7));
      x.lo    = 2'($urandom);
      x.we    = $urandom_range(0, 7) != 0;
      x.wa    = 5'($urandom);
      x.res   = $urandom;
      x.rd    = $urandom;
      cyc(x);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
